// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller: FSM state encoding, BCD limit, all-nines test.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } sw_state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam int         MAX_DIGITS = 8;

   // True when the lowest n BCD digits of d are all 9.
   function automatic logic all_nines(input logic [4*MAX_DIGITS-1:0] d, input int n);
      logic r;
      r = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < n && d[4*i +: 4] != BCD_MAX) r = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse inputs and display-side outputs of the stopwatch controller.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are consumed in the cycle they are presented.
interface stopwatch_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start_stop;
   logic                  lap;
   logic                  clear;
   logic [4*DIGITS-1:0]   digits_out;
   logic                  running;
   logic                  lap_active;
   logic                  overflow;

   // Button source / display sink side
   modport master (
      output start_stop, lap, clear,
      input  digits_out, running, lap_active, overflow
   );

   // Controller side
   modport slave (
      input  start_stop, lap, clear,
      output digits_out, running, lap_active, overflow
   );
endinterface

// File: rtl/bcd_digit_cnt.sv
// One synchronous mod-10 digit of the stopwatch chain; at_max flags 9 for the carry into the next digit.
// Latency: q updates on the edge where inc (or clr) is sampled high.
// Backpressure: none; clr overrides inc.
module bcd_digit_cnt
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       at_max
);

   // Count 0..9 and wrap; clear wins over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      end
   end

   assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch: prescaler gates ticks into a DIGITS-long BCD chain, FSM handles pause/lap/clear.
// Latency: first increment TICK_DIV cycles after entering RUN; outputs change on the edge of the causing event.
// Backpressure: none; inputs are single-cycle pulses, priority clear > start_stop > lap. Option: STOPWATCH_SATURATE_EN.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic reset,
   stopwatch_ctrl_if.slave sw
);

   localparam int            PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   sw_state_t             state;
   logic [PW-1:0]         presc;
   logic [4*DIGITS-1:0]   live;
   logic [4*DIGITS-1:0]   lap_q;
   logic [DIGITS-1:0]     at_max;
   logic [DIGITS-1:0]     carry;
   logic [DIGITS-1:0]     inc;
   logic                  active;
   logic                  tick;
   logic                  top_hit;
   logic                  stop_hit;
   logic                  resume_ok;
   logic                  running;
   logic                  lap_act;
   logic                  ovf;

   assign active  = (state == ST_RUN) || (state == ST_LAP);
   assign tick    = active && (presc == PRE_LAST);
   assign top_hit = tick && all_nines(32'(live), DIGITS);

`ifdef STOPWATCH_SATURATE_EN
   // Reaching all-9s freezes the chain and parks the FSM until clear/reset.
   assign stop_hit  = top_hit;
   assign resume_ok = ~ovf;
`else
   assign stop_hit  = 1'b0;
   assign resume_ok = 1'b1;
`endif

   // Carry: digit g steps when the tick arrives and every lower digit is at 9.
   assign carry[0] = tick;
   for (genvar g = 1; g < DIGITS; g++) begin : g_carry
      assign carry[g] = carry[g-1] & at_max[g-1];
   end

   assign inc = carry & {DIGITS{~stop_hit}};

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_cnt u_digit (
         .clk    (clk),
         .reset  (reset),
         .clr    (sw.clear),
         .inc    (inc[g]),
         .q      (live[4*g +: 4]),
         .at_max (at_max[g])
      );
   end

   // Prescaler advances only while counting, so a pause keeps the partial tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (sw.clear) begin
         presc <= '0;
      end else if (active) begin
         presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
      end
   end

   // FSM with lap capture and sticky overflow; running/lap_active registered with the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         running <= 1'b0;
         lap_act <= 1'b0;
         ovf     <= 1'b0;
         lap_q   <= '0;
      end else if (sw.clear) begin
         state   <= ST_IDLE;
         running <= 1'b0;
         lap_act <= 1'b0;
         ovf     <= 1'b0;
         lap_q   <= '0;
      end else begin
         if (top_hit) ovf <= 1'b1;
         if (stop_hit) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
            lap_act <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (sw.start_stop) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (sw.start_stop) begin
                     state   <= ST_PAUSE;
                     running <= 1'b0;
                  end else if (sw.lap) begin
                     state   <= ST_LAP;
                     lap_act <= 1'b1;
                     lap_q   <= live;
                  end
               end
               ST_LAP: begin
                  if (sw.start_stop) begin
                     state   <= ST_PAUSE;
                     running <= 1'b0;
                     lap_act <= 1'b0;
                  end else if (sw.lap) begin
                     state   <= ST_RUN;
                     lap_act <= 1'b0;
                  end
               end
               ST_PAUSE: begin
                  if (sw.start_stop && resume_ok) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
                  lap_act <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sw.digits_out = lap_act ? lap_q : live;
   assign sw.running    = running;
   assign sw.lap_active = lap_act;
   assign sw.overflow   = ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench: directed scenarios plus randomized pulses against an integer-valued stopwatch model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_ctrl;

   localparam int T    = 4;
   localparam int MAXV = 99;
`ifdef STOPWATCH_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic rst6;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: mode 0 idle, 1 run, 2 pause, 3 lap; counts held as plain integers
   int m_mode, m_count, m_lap, m_phase;
   bit m_ovf;

   stopwatch_ctrl_if #(.DIGITS(2)) sw ();
   stopwatch_ctrl_if #(.DIGITS(4)) sw6 ();

   stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(4)) dut  (.clk(clk), .reset(rst),  .sw(sw));
   stopwatch_ctrl #(.DIGITS(4), .TICK_DIV(2)) dut6 (.clk(clk), .reset(rst6), .sw(sw6));

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] exp_digits();
      return to_bcd2(m_mode == 3 ? m_lap : m_count);
   endfunction

   task automatic model_step(input bit ss, input bit lp, input bit cl);
      int nxt;
      bit active, tick, top;
      if (cl) begin
         m_mode = 0; m_count = 0; m_lap = 0; m_phase = 0; m_ovf = 1'b0;
         return;
      end
      active = (m_mode == 1) || (m_mode == 3);
      tick   = active && (m_phase == T - 1);
      if (active) m_phase = (m_phase + 1) % T;
      top = tick && (m_count == MAXV);
      nxt = m_count;
      if (tick) nxt = top ? (SAT ? m_count : 0) : m_count + 1;
      if (top) m_ovf = 1'b1;
      if (SAT && top) m_mode = 2;
      else begin
         case (m_mode)
            0: if (ss) m_mode = 1;
            1: if (ss) m_mode = 2; else if (lp) begin m_mode = 3; m_lap = m_count; end
            3: if (ss) m_mode = 2; else if (lp) m_mode = 1;
            2: if (ss && !(SAT && m_ovf)) m_mode = 1;
            default: m_mode = 0;
         endcase
      end
      m_count = nxt;
   endtask

   // One clock with the given pulses; outputs are stable at return (1 time unit after the edge)
   task automatic cyc(input bit ss, input bit lp, input bit cl);
      sw.start_stop = ss; sw.lap = lp; sw.clear = cl;
      @(posedge clk);
      model_step(ss, lp, cl);
      #1;
      sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      sw.start_stop = 0; sw.lap = 0; sw.clear = 0;
      sw6.start_stop = 0; sw6.lap = 0; sw6.clear = 0;
      rst = 1'b1; rst6 = 1'b1;
      m_mode = 0; m_count = 0; m_lap = 0; m_phase = 0; m_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (sw.digits_out !== 8'h00) begin n_fail++; $display("FAIL reset_digits got=%h want=00", sw.digits_out); end
      n_checks++; if (sw.running !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%b want=0", sw.running); end
      n_checks++; if (sw.lap_active !== 1'b0) begin n_fail++; $display("FAIL reset_lap got=%b want=0", sw.lap_active); end
      n_checks++; if (sw.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", sw.overflow); end
      n_checks++; if (sw6.digits_out !== 16'h0000) begin n_fail++; $display("FAIL reset6_digits got=%h want=0000", sw6.digits_out); end
      rst = 1'b0; rst6 = 1'b0;
      idle(5);
      n_checks++; if (sw.digits_out !== 8'h00 || sw.running !== 1'b0) begin n_fail++; $display("FAIL idle_hold got=%h/%b want=00/0", sw.digits_out, sw.running); end
   endtask

   task automatic test_count();
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++; if (sw.running !== 1'b1) begin n_fail++; $display("FAIL start_running got=%b want=1", sw.running); end
      idle(3);
      n_checks++; if (sw.digits_out !== 8'h00) begin n_fail++; $display("FAIL pre_first_tick got=%h want=00", sw.digits_out); end
      idle(1);
      n_checks++; if (sw.digits_out !== 8'h01) begin n_fail++; $display("FAIL first_tick got=%h want=01", sw.digits_out); end
      idle(4);
      n_checks++; if (sw.digits_out !== 8'h02) begin n_fail++; $display("FAIL second_tick got=%h want=02", sw.digits_out); end
      idle(32);
      n_checks++; if (sw.digits_out !== 8'h10) begin n_fail++; $display("FAIL carry_10 got=%h want=10", sw.digits_out); end
   endtask

   task automatic test_pause();
      idle(108);
      n_checks++; if (sw.digits_out !== 8'h37) begin n_fail++; $display("FAIL reach_37 got=%h want=37", sw.digits_out); end
      idle(1);
      cyc(1'b1, 1'b0, 1'b0);
      idle(20);
      n_checks++; if (sw.digits_out !== 8'h37 || sw.running !== 1'b0) begin n_fail++; $display("FAIL pause_hold got=%h/%b want=37/0", sw.digits_out, sw.running); end
      cyc(1'b1, 1'b0, 1'b0);
      idle(1);
      n_checks++; if (sw.digits_out !== 8'h37) begin n_fail++; $display("FAIL resume_early got=%h want=37", sw.digits_out); end
      idle(1);
      n_checks++; if (sw.digits_out !== 8'h38) begin n_fail++; $display("FAIL resume_partial got=%h want=38", sw.digits_out); end
   endtask

   task automatic test_lap();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      idle(60);
      n_checks++; if (sw.digits_out !== 8'h15) begin n_fail++; $display("FAIL reach_15 got=%h want=15", sw.digits_out); end
      cyc(1'b0, 1'b1, 1'b0);
      n_checks++; if (sw.lap_active !== 1'b1 || sw.running !== 1'b1) begin n_fail++; $display("FAIL lap_enter got=%b/%b want=1/1", sw.lap_active, sw.running); end
      idle(11);
      n_checks++; if (sw.digits_out !== 8'h15) begin n_fail++; $display("FAIL lap_frozen got=%h want=15", sw.digits_out); end
      cyc(1'b0, 1'b1, 1'b0);
      n_checks++; if (sw.digits_out !== 8'h18 || sw.lap_active !== 1'b0) begin n_fail++; $display("FAIL lap_exit got=%h/%b want=18/0", sw.digits_out, sw.lap_active); end
   endtask

   task automatic test_overflow();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      idle(392);
      n_checks++; if (sw.digits_out !== 8'h98 || sw.overflow !== 1'b0) begin n_fail++; $display("FAIL reach_98 got=%h/%b want=98/0", sw.digits_out, sw.overflow); end
      idle(4);
      n_checks++; if (sw.digits_out !== 8'h99) begin n_fail++; $display("FAIL reach_99 got=%h want=99", sw.digits_out); end
      idle(4);
      if (SAT) begin
         n_checks++; if (sw.digits_out !== 8'h99 || sw.overflow !== 1'b1 || sw.running !== 1'b0) begin n_fail++; $display("FAIL saturate got=%h/%b/%b want=99/1/0", sw.digits_out, sw.overflow, sw.running); end
         cyc(1'b1, 1'b0, 1'b0);
         idle(8);
         n_checks++; if (sw.running !== 1'b0 || sw.digits_out !== 8'h99) begin n_fail++; $display("FAIL sat_locked got=%h/%b want=99/0", sw.digits_out, sw.running); end
      end else begin
         n_checks++; if (sw.digits_out !== 8'h00 || sw.overflow !== 1'b1 || sw.running !== 1'b1) begin n_fail++; $display("FAIL wrap got=%h/%b/%b want=00/1/1", sw.digits_out, sw.overflow, sw.running); end
         idle(4);
         n_checks++; if (sw.digits_out !== 8'h01 || sw.overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky got=%h/%b want=01/1", sw.digits_out, sw.overflow); end
      end
      cyc(1'b0, 1'b0, 1'b1);
      n_checks++; if (sw.overflow !== 1'b0 || sw.digits_out !== 8'h00) begin n_fail++; $display("FAIL clear_ovf got=%h/%b want=00/0", sw.digits_out, sw.overflow); end
   endtask

   task automatic test_clear_priority();
      cyc(1'b1, 1'b0, 1'b0);
      idle(168);
      n_checks++; if (sw.digits_out !== 8'h42) begin n_fail++; $display("FAIL reach_42 got=%h want=42", sw.digits_out); end
      cyc(1'b1, 1'b0, 1'b1);
      n_checks++; if (sw.digits_out !== 8'h00 || sw.running !== 1'b0 || sw.overflow !== 1'b0 || sw.lap_active !== 1'b0) begin n_fail++; $display("FAIL clear_prio got=%h/%b/%b want=00/0/0", sw.digits_out, sw.running, sw.overflow); end
      idle(8);
      n_checks++; if (sw.digits_out !== 8'h00 || sw.running !== 1'b0) begin n_fail++; $display("FAIL clear_idle got=%h/%b want=00/0", sw.digits_out, sw.running); end
   endtask

   task automatic test_random();
      bit ss, lp, cl;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      idle(380);
      for (int i = 0; i < 800; i++) begin
         ss = ($urandom_range(0, 15) == 0);
         lp = ($urandom_range(0, 9) == 0);
         cl = ($urandom_range(0, 249) == 0);
         cyc(ss, lp, cl);
         n_checks++; if (sw.digits_out !== exp_digits()) begin n_fail++; $display("FAIL rnd_digits cyc=%0d got=%h want=%h", i, sw.digits_out, exp_digits()); end
         n_checks++; if (sw.running !== ((m_mode == 1) || (m_mode == 3))) begin n_fail++; $display("FAIL rnd_running cyc=%0d got=%b mode=%0d", i, sw.running, m_mode); end
         n_checks++; if (sw.lap_active !== (m_mode == 3)) begin n_fail++; $display("FAIL rnd_lap cyc=%0d got=%b mode=%0d", i, sw.lap_active, m_mode); end
         n_checks++; if (sw.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", i, sw.overflow, m_ovf); end
      end
   endtask

   task automatic test_async_reset();
      sw6.start_stop = 1'b1;
      @(posedge clk); #1;
      sw6.start_stop = 1'b0;
      n_checks++; if (sw6.running !== 1'b1) begin n_fail++; $display("FAIL r6_start got=%b want=1", sw6.running); end
      repeat (10) @(posedge clk);
      #1;
      n_checks++; if (sw6.digits_out !== 16'h0005) begin n_fail++; $display("FAIL r6_count got=%h want=0005", sw6.digits_out); end
      #2;
      rst6 = 1'b1;
      #1;
      n_checks++; if (sw6.digits_out !== 16'h0000 || sw6.running !== 1'b0 || sw6.lap_active !== 1'b0 || sw6.overflow !== 1'b0) begin n_fail++; $display("FAIL r6_async got=%h/%b want=0000/0", sw6.digits_out, sw6.running); end
      @(posedge clk); #1;
      rst6 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (sw6.digits_out !== 16'h0000 || sw6.running !== 1'b0) begin n_fail++; $display("FAIL r6_post got=%h/%b want=0000/0", sw6.digits_out, sw6.running); end
      sw6.start_stop = 1'b1;
      @(posedge clk); #1;
      sw6.start_stop = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (sw6.digits_out !== 16'h0000) begin n_fail++; $display("FAIL r6_early got=%h want=0000", sw6.digits_out); end
      @(posedge clk); #1;
      n_checks++; if (sw6.digits_out !== 16'h0001) begin n_fail++; $display("FAIL r6_first got=%h want=0001", sw6.digits_out); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_pause();
      test_lap();
      test_overflow();
      test_clear_priority();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
